// File: rtl/fifo_stream_reader_if.sv
// Control, FIFO read-port and output-stream signals of fifo_stream_reader.
// master = the reader itself, slave = its environment (FIFO, consumer, controller).
interface fifo_stream_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
);
  logic                  start;
  logic [LEN_WIDTH-1:0]  len;
  logic                  busy;
  logic                  done;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_empty;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;
  logic [LEN_WIDTH-1:0]  words_out;

  modport master (
    input  start, len, fifo_data, fifo_empty, m_ready,
    output busy, done, fifo_rd_en, m_valid, m_data, m_last, words_out
  );

  modport slave (
    output start, len, fifo_data, fifo_empty, m_ready,
    input  busy, done, fifo_rd_en, m_valid, m_data, m_last, words_out
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains a programmed number of words from a synchronous FIFO onto a valid/ready
// stream, using a 2-entry buffer to hide the FIFO read latency and backpressure.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_stream_reader_if.master bus_io
);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0] LEN_ZERO = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  issued_q, issued_d;
  logic [LEN_WIDTH-1:0]  accepted_q, accepted_d;
  logic [LEN_WIDTH-1:0]  words_q, words_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            occ_q, occ_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
  logic [DATA_WIDTH-1:0] buf1_q, buf1_d;

  logic                  pop_s;
  logic                  last_s;
  logic                  rd_en_s;
  logic [2:0]            level_s;
  logic [1:0]            wr_pos_s;

  // Handshake decode and read-issue gating; level_s is the post-pop slot usage
  always_comb begin
    pop_s    = (occ_q != 2'd0) && bus_io.m_ready;
    last_s   = (occ_q != 2'd0) && (accepted_q == (len_q - LEN_ONE));
    level_s  = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop_s};
    rd_en_s  = (state_q == ST_READ) && !bus_io.fifo_empty &&
               (issued_q < len_q) && (level_s < 3'd2);
    wr_pos_s = occ_q - {1'b0, pop_s};
  end

  // Output buffer: entry 0 is the head; the returning FIFO word lands behind what survives the pop
  always_comb begin
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    inflight_d = rd_en_s;
    occ_d      = occ_q + {1'b0, inflight_q} - {1'b0, pop_s};
    if (pop_s) begin
      buf0_d = buf1_q;
    end else begin
      buf0_d = buf0_q;
    end
    if (inflight_q) begin
      case (wr_pos_s)
        2'd0:    buf0_d = bus_io.fifo_data;
        2'd1:    buf1_d = bus_io.fifo_data;
        default: buf1_d = buf1_q;
      endcase
    end else begin
      buf1_d = buf1_d;
    end
  end

  // Burst FSM and counters
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    issued_d   = issued_q;
    accepted_d = accepted_q;
    words_d    = words_q;
    case (state_q)
      ST_IDLE: begin
        if (bus_io.start) begin
          words_d = LEN_ZERO;
          if (bus_io.len != LEN_ZERO) begin
            len_d      = bus_io.len;
            issued_d   = LEN_ZERO;
            accepted_d = LEN_ZERO;
            state_d    = ST_READ;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (rd_en_s) begin
          issued_d = issued_q + LEN_ONE;
        end else begin
          issued_d = issued_q;
        end
        if (pop_s) begin
          accepted_d = accepted_q + LEN_ONE;
          words_d    = words_q + LEN_ONE;
          if (last_s) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_READ;
          end
        end else begin
          state_d = ST_READ;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset also drops any word already requested from the FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      len_q      <= LEN_ZERO;
      issued_q   <= LEN_ZERO;
      accepted_q <= LEN_ZERO;
      words_q    <= LEN_ZERO;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      buf0_q     <= '0;
      buf1_q     <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      accepted_q <= accepted_d;
      words_q    <= words_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
    end
  end

  assign bus_io.busy       = (state_q == ST_READ);
  assign bus_io.done       = (state_q == ST_DONE);
  assign bus_io.fifo_rd_en = rd_en_s;
  assign bus_io.m_valid    = (occ_q != 2'd0);
  assign bus_io.m_data     = buf0_q;
  assign bus_io.m_last     = last_s;
  assign bus_io.words_out  = words_q;
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: FIFO model on the read port, scoreboard of
// expected words filled as the FIFO is written and drained on each handshake.
module tb_fifo_stream_reader;
  localparam int DW = 8;
  localparam int LW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_stream_reader_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();
  fifo_stream_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus)
  );

  // Synchronous FIFO model: registered read data and registered empty flag
  logic [DW-1:0] fifo_q[$];
  logic          wr_en_s     = 1'b0;
  logic [DW-1:0] wr_data_s   = '0;
  logic          flush_s     = 1'b0;
  logic [DW-1:0] fifo_dout_r = '0;
  logic          fifo_empty_r = 1'b1;

  always @(posedge clk) begin
    if (flush_s) begin
      fifo_q.delete();
    end else begin
      if (bus.fifo_rd_en && fifo_q.size() != 0) fifo_dout_r <= fifo_q.pop_front();
      if (wr_en_s) fifo_q.push_back(wr_data_s);
    end
    fifo_empty_r <= (fifo_q.size() == 0);
  end
  assign bus.fifo_data  = fifo_dout_r;
  assign bus.fifo_empty = fifo_empty_r;

  logic [DW-1:0] exp_q[$];
  int n_checks = 0, n_errors = 0;
  int cyc = 0, start_cyc = 0, cur_len = 0, done_cnt = 0;
  int xfer_cnt = 0, xfer_first = 0, xfer_last = 0, xfer_tot = 0;
  int rd_cnt = 0, rd_first = 0, rd_last = 0, issued_tot = 0;
  int ready_mode = 0;
  logic prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        issued_tot = 0;
        xfer_tot   = 0;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check_val("stall_valid", bus.m_valid, 1);
          check_val("stall_data", bus.m_data, prev_data);
        end
        if (bus.done) done_cnt++;
        if (bus.fifo_rd_en) begin
          check_val("rd_on_empty", bus.fifo_empty, 0);
          if (rd_cnt == 0) rd_first = cyc;
          rd_last = cyc;
          rd_cnt++;
          issued_tot++;
        end
        if (bus.m_valid) check_val("m_last", bus.m_last, (xfer_cnt == cur_len - 1));
        if (bus.m_valid && bus.m_ready) begin
          if (exp_q.size() == 0) check_val("sb_underrun", exp_q.size(), 1);
          else check_val("m_data", bus.m_data, exp_q.pop_front());
          if (xfer_cnt == 0) xfer_first = cyc;
          xfer_last = cyc;
          xfer_cnt++;
          xfer_tot++;
        end
        if (bus.fifo_rd_en) check_val("outstanding_le2", (issued_tot - xfer_tot <= 2), 1);
        prev_stall = bus.m_valid && !bus.m_ready;
        prev_data  = bus.m_data;
      end
    end
  endtask

  // m_ready: held high, or stalled 5 cycles after the first valid then toggling
  task automatic ready_driver();
    int   bp   = 0;
    logic seen = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) begin
        bus.m_ready = 1'b1;
        seen = 1'b0;
        bp   = 0;
      end else begin
        if (bus.m_valid) seen = 1'b1;
        if (seen) bp++;
        bus.m_ready = (bp > 5) && (bp % 2 == 0);
      end
    end
  endtask

  task automatic fifo_write(input logic [DW-1:0] d, input bit expect_it);
    wr_en_s   = 1'b1;
    wr_data_s = d;
    if (expect_it) exp_q.push_back(d);
    tick(1);
    wr_en_s = 1'b0;
  endtask

  task automatic start_burst(input int l);
    cur_len   = l;
    xfer_cnt  = 0;
    rd_cnt    = 0;
    start_cyc = cyc;
    bus.start = 1'b1;
    bus.len   = LW'(l);
    tick(1);
    bus.start = 1'b0;
    bus.len   = 8'h5A;
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_cnt;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt > d0) break;
      tick(1);
    end
    tick(3);
    check_val("done_once", done_cnt - d0, 1);
    check_val("idle_after_done", bus.busy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_busy"}, bus.busy, 0);
    check_val({tag, "_done"}, bus.done, 0);
    check_val({tag, "_rd_en"}, bus.fifo_rd_en, 0);
    check_val({tag, "_m_valid"}, bus.m_valid, 0);
    check_val({tag, "_m_data"}, bus.m_data, 0);
    check_val({tag, "_m_last"}, bus.m_last, 0);
    check_val({tag, "_words_out"}, bus.words_out, 0);
  endtask

  initial begin
    int d0;
    bus.start   = 1'b0;
    bus.len     = '0;
    bus.m_ready = 1'b1;
    fork
      monitor();
      ready_driver();
    join_none

    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    tick(2);

    // Full-rate burst
    for (int i = 1; i <= 8; i++) fifo_write(DW'(i), 1'b1);
    tick(1);
    start_burst(8);
    wait_done(40);
    check_val("full_rd_cnt", rd_cnt, 8);
    check_val("full_rd_first", rd_first - start_cyc, 2);
    check_val("full_rd_last", rd_last - start_cyc, 9);
    check_val("full_xfer_cnt", xfer_cnt, 8);
    check_val("full_xfer_first", xfer_first - start_cyc, 4);
    check_val("full_xfer_last", xfer_last - start_cyc, 11);
    check_val("full_words_out", bus.words_out, 8);
    check_val("full_fifo_empty", bus.fifo_empty, 1);
    check_val("full_sb_empty", exp_q.size(), 0);

    // Backpressure
    ready_mode = 1;
    for (int i = 1; i <= 8; i++) fifo_write(DW'(i), 1'b1);
    tick(1);
    start_burst(8);
    wait_done(120);
    ready_mode = 0;
    check_val("bp_xfer_cnt", xfer_cnt, 8);
    check_val("bp_rd_cnt", rd_cnt, 8);
    check_val("bp_words_out", bus.words_out, 8);
    check_val("bp_sb_empty", exp_q.size(), 0);
    tick(2);

    // Underflow stall
    fifo_write(8'hA0, 1'b1);
    fifo_write(8'hA1, 1'b1);
    tick(1);
    start_burst(4);
    for (int i = 0; i < 10; i++) begin
      check_val("gap_busy", bus.busy, 1);
      tick(1);
    end
    check_val("gap_drained", xfer_cnt, 2);
    fifo_write(8'hA2, 1'b1);
    fifo_write(8'hA3, 1'b1);
    wait_done(40);
    check_val("uf_xfer_cnt", xfer_cnt, 4);
    check_val("uf_words_out", bus.words_out, 4);
    check_val("uf_sb_empty", exp_q.size(), 0);

    // Zero length
    d0 = done_cnt;
    start_burst(0);
    check_val("zero_done", bus.done, 1);
    check_val("zero_words_out", bus.words_out, 0);
    tick(3);
    check_val("zero_done_cnt", done_cnt - d0, 1);
    check_val("zero_rd_cnt", rd_cnt, 0);

    // Start during a burst is ignored
    for (int i = 0; i < 6; i++) fifo_write(DW'(8'h30 + i), (i < 4));
    tick(1);
    start_burst(4);
    tick(1);
    bus.start = 1'b1;
    bus.len   = 8'd7;
    tick(1);
    bus.start = 1'b0;
    wait_done(40);
    check_val("ign_xfer_cnt", xfer_cnt, 4);
    check_val("ign_rd_cnt", rd_cnt, 4);
    check_val("ign_words_out", bus.words_out, 4);
    check_val("ign_sb_empty", exp_q.size(), 0);
    flush_s = 1'b1;
    tick(1);
    flush_s = 1'b0;
    tick(1);

    // Reset mid-burst, then a fresh burst
    for (int i = 0; i < 8; i++) fifo_write(DW'(8'h11 + i), 1'b1);
    tick(1);
    start_burst(8);
    for (int i = 0; i < 30; i++) begin
      if (xfer_cnt >= 3) break;
      tick(1);
    end
    check_val("pre_reset_xfers", (xfer_cnt >= 3), 1);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    exp_q.delete();
    tick(1);
    flush_s = 1'b1;
    tick(1);
    flush_s = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(1);
    for (int i = 0; i < 5; i++) fifo_write(DW'(8'h21 + i), 1'b1);
    tick(1);
    start_burst(5);
    wait_done(40);
    check_val("rst2_xfer_cnt", xfer_cnt, 5);
    check_val("rst2_consecutive", xfer_last - xfer_first, 4);
    check_val("rst2_words_out", bus.words_out, 5);
    check_val("rst2_sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Drain side of the synchronous FIFO. On a `start` command it pulls a programmed number of words out of the FIFO's read port (`rd_en`/`data_out`/`empty`) and presents them on a valid/ready output stream, marking the final word with `m_last`. A 2-entry output buffer absorbs the FIFO's one-cycle read latency and downstream backpressure without losing or duplicating words. It sits between the FIFO and any streaming consumer (serializer, DMA, bus bridge).

## Interface

Parameters:
- `DATA_WIDTH`, default 8: word width; must match the FIFO.
- `LEN_WIDTH`, default 8: width of the burst length and word counter.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  burst command, one-cycle pulse; sampled only in IDLE.
- `len`  in  LEN_WIDTH  burst length in words; sampled with `start`.
- `busy`  out  1  high while state is READ.
- `done`  out  1  one-cycle pulse when a burst completes.
- `fifo_rd_en`  out  1  to FIFO `rd_en`.
- `fifo_data`  in  DATA_WIDTH  from FIFO `data_out`.
- `fifo_empty`  in  1  from FIFO `empty`.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  downstream accepts the word.
- `m_data`  out  DATA_WIDTH  output word.
- `m_last`  out  1  qualifies the final word of the burst; meaningful only with `m_valid`.
- `words_out`  out  LEN_WIDTH  count of words accepted in the current or most recent burst.

## Operation

- FSM states: IDLE, READ, DONE. Reset state: IDLE.
- IDLE: `start`=1 and `len`!=0 -> latch `len`, clear issue count, accepted count and `words_out` -> READ. `start`=1 and `len`=0 -> clear `words_out` -> DONE. Otherwise stay.
- READ: issue FIFO reads and deliver words. When the handshake on the word with `m_last` completes -> DONE.
- DONE: `done`=1 for exactly one cycle -> IDLE.
- `start` outside IDLE is ignored. `len` changes after sampling have no effect.
- Read issue (combinational): `fifo_rd_en` = READ and !`fifo_empty` and issued < latched_len and (occ + inflight - pop) < 2. Here occ is the buffer occupancy (0..2), inflight is 1 if `fifo_rd_en` was high on the previous cycle, and pop = `m_valid` and `m_ready`.
- The FIFO word requested at edge N appears on `fifo_data` after N and is written into the buffer at edge N+1. The buffer never overflows.
- Buffer is FIFO-ordered. `m_valid` = occ != 0; `m_data` = head entry.
- `m_last` = `m_valid` and (accepted count == latched_len - 1).
- Handshake: a word transfers on an edge where `m_valid` and `m_ready` are both high. `m_data`/`m_valid` stay stable while `m_valid`=1 and `m_ready`=0.
- `words_out` increments on each transfer and holds its value after `done` until the next `start`.
- Counters are LEN_WIDTH wide; `len` up to 2^LEN_WIDTH-1; no wrap within a burst.
- `fifo_empty` high in READ: `fifo_rd_en` is held low; buffered words still drain; the burst resumes when data arrives. No timeout.
- Reset, any state: async clear of FSM, buffer, counters and in-flight flag. Any word already requested from the FIFO is discarded.

## Timing

- Reset values: `busy`=0, `done`=0, `fifo_rd_en`=0, `m_valid`=0, `m_data`=0, `m_last`=0, `words_out`=0.
- `start` sampled at edge E0. With the FIFO non-empty, `fifo_rd_en` is high in the cycle after E0 and `m_valid` rises after E0+2.
- Throughput: 1 word/clock with `m_ready` held high and the FIFO non-empty. There is a combinational path from `m_ready` to `fifo_rd_en`.
- Backpressure: at most 2 words are buffered. `fifo_rd_en` drops within the same cycle the limit would be exceeded.
- Final handshake at edge Ef -> `done`=1 in the cycle after Ef, IDLE one cycle later.
- `len`=0: `done`=1 in the cycle after E0; `fifo_rd_en` is never asserted.

## Test plan

- Reset: assert `rst` asynchronously mid-cycle -> all outputs 0 immediately, state IDLE.
- Full-rate burst: FIFO holds 0x01..0x08, `len`=8, `m_ready`=1 -> `fifo_rd_en` high 8 consecutive cycles starting the cycle after `start`; `m_data` 0x01..0x08 on 8 consecutive cycles; `m_last` only with 0x08; `done` pulses once; `words_out`=8; `fifo_empty`=1 at the end.
- Backpressure: `len`=8, `m_ready`=0 for 5 cycles after the first `m_valid`, then toggling -> `m_data` held stable while stalled; no more than 2 outstanding-plus-buffered reads; output sequence exactly 0x01..0x08 with no loss or duplicate.
- Underflow stall: FIFO holds 0xA0, 0xA1; `len`=4; write 0xA2, 0xA3 10 cycles later -> `fifo_rd_en` low while `fifo_empty`=1; output A0..A3; `m_last` with A3; `busy` stays high throughout the gap.
- Zero length and ignored start: `start` with `len`=0 -> `done` next cycle, `fifo_rd_en` never high, `words_out`=0. A `start` pulse during a `len`=4 burst -> ignored; exactly 4 words transferred.
- Reset mid-burst: `len`=8, assert `rst` after 3 transfers -> outputs cleared. Then a new burst with `len`=5 -> 5 consecutive FIFO words, `words_out`=5, `done` once.
